// File: rtl/phy_pkg.sv
// phy_pkg: shared widths, frame phases and byte selection
// for the byte-lane serializer.
package phy_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef logic [$clog2(BYTES_PER_WORD)-1:0] phase_t;

  localparam phase_t PH_B0 = 2'd0;
  localparam phase_t PH_B1 = 2'd1;
  localparam phase_t PH_B2 = 2'd2;
  localparam phase_t PH_B3 = 2'd3;

  // MSB-first: phase 0 carries the top byte.
  function automatic logic [BYTE_W-1:0] word_byte(
    input logic [WORD_W-1:0] w,
    input phase_t            ph
  );
    logic [BYTE_W-1:0] b;
    b = '0;
    unique case (ph)
      PH_B0: b = w[31:24];
      PH_B1: b = w[23:16];
      PH_B2: b = w[15:8];
      PH_B3: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching
// upward from the slot after the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en_i && !any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/byte_lane_sched.sv
// byte_lane_sched: round-robin word scheduler serializing
// one 32-bit word per 4-cycle phase-aligned byte frame.
module byte_lane_sched
  import phy_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk_4f,
  input  logic                      reset,
  input  logic                      sched_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_pop,
  output logic                      valid_out,
  output logic [BYTE_W-1:0]         data_out,
  output logic [ID_W-1:0]           chan_out,
  output logic                      frame_start,
  output logic                      busy
);

  phase_t              ph_q, ph_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     chan_q, chan_d;
  logic                start_q, start_d;

  logic                arb_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [WORD_W-1:0]   sel_word;

  assign arb_en = (ph_q == PH_B3) && sched_en && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i  (req_valid),
    .last_i (rr_q),
    .en_i   (arb_en),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_word = req_data[i*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    ph_d    = ph_q + 2'd1;
    rr_d    = rr_q;
    word_d  = word_q;
    valid_d = valid_q;
    data_d  = '0;
    chan_d  = chan_q;
    start_d = 1'b0;
    if (ph_q == PH_B3) begin
      // Grant edge: next frame loads while the last byte drains.
      valid_d = gnt_any;
      start_d = gnt_any;
      if (gnt_any) begin
        word_d = sel_word;
        rr_d   = gnt_idx;
        chan_d = gnt_idx;
        data_d = word_byte(sel_word, PH_B0);
      end
    end else if (valid_q) begin
      data_d = word_byte(word_q, ph_d);
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      ph_q    <= PH_B3;
      rr_q    <= ID_W'(NUM_REQ - 1);
      word_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      start_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      rr_q    <= rr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      start_q <= start_d;
    end
  end

  assign req_pop     = gnt;
  assign valid_out   = valid_q;
  assign data_out    = data_q;
  assign chan_out    = chan_q;
  assign frame_start = start_q;
  assign busy        = valid_q;

endmodule
